prng_arbiter: RTL and testbench

Sequencing and sharing controller for the 43-bit LFSR / 37-cell CA random number generator. It seeds the generator, runs a discard warm-up, then arbitrates round-robin among NUM_REQ requesters (dropout-mask and weight-init units of the RNN datapath), delivering one fresh 32-bit sample per grant. It owns every control pin of the generator (seed, reset, enable, fetchSample) and is the only agent allowed to drive them.

---
 rtl/prng_arbiter.sv | 125 ++++++++++++
 tb/tb_prng_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/prng_arbiter.sv
// prng_arbiter: seeds and warms up the LFSR/CA generator, then round-robins fresh samples to NUM_REQ requesters; 1-cycle grant-to-sample latency, no backpressure (req levels).
// Optional delivered-sample counter is built only when PRNG_ARB_STATS_EN is defined; otherwise sample_count is tied to 0.
module prng_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int SEED_size     = 43,
  parameter int OUT_size      = 32,
  parameter int WARMUP_CYCLES = 64,
  parameter logic [SEED_size-1:0] DEFAULT_SEED = 43'h5A5_C3C3_A5A5
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [SEED_size-1:0]       seed_in,
  input  logic                       reseed,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       ready,
  output logic                       sample_valid,
  output logic [$clog2(NUM_REQ)-1:0] sample_id,
  output logic [OUT_size-1:0]        sample_data,
  output logic [31:0]                sample_count,
  output logic [SEED_size-1:0]       prng_seed,
  output logic                       prng_reset,
  output logic                       prng_enable,
  output logic                       prng_fetch,
  input  logic [OUT_size-1:0]        prng_data
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam logic [IDW-1:0] LAST_IDX  = IDW'(NUM_REQ - 1);
  localparam logic [IDW-1:0] ONE_IDX   = IDW'(1);
  localparam logic [15:0]    WARM_LAST = 16'(WARMUP_CYCLES - 1);

  typedef enum logic [1:0] {RST, SEED, WARMUP, SERVE} state_t;

  state_t               state;
  logic [SEED_size-1:0] seed_q;
  logic [SEED_size-1:0] seed_sel;
  logic [15:0]          warm_cnt;
  logic [IDW-1:0]       rr_ptr;
  logic [IDW-1:0]       gnt_idx;
  logic [IDW-1:0]       cand;
  logic                 gnt_any;

  // A zero seed would lock the LFSR, so it is replaced at every load point.
  assign seed_sel = (seed_in == '0) ? DEFAULT_SEED : seed_in;

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = rr_ptr;
    grant   = '0;
    if (state == SERVE && !reseed) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!gnt_any && req[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
        cand = (cand == LAST_IDX) ? '0 : cand + ONE_IDX;
      end
      grant[gnt_idx] = gnt_any;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= RST;
      seed_q       <= seed_sel;
      warm_cnt     <= '0;
      rr_ptr       <= '0;
      sample_valid <= 1'b0;
      sample_id    <= '0;
    end else begin
      sample_valid <= gnt_any;
      if (gnt_any) sample_id <= gnt_idx;
      case (state)
        RST: state <= SEED;
        SEED: begin
          warm_cnt <= '0;
          if (reseed) seed_q <= seed_sel;
          else        state  <= WARMUP;
        end
        WARMUP: begin
          if (reseed) begin
            seed_q   <= seed_sel;
            warm_cnt <= '0;
            state    <= SEED;
          end else if (warm_cnt == WARM_LAST) begin
            state <= SERVE;
          end else begin
            warm_cnt <= warm_cnt + 16'd1;
          end
        end
        SERVE: begin
          if (reseed) begin
            seed_q <= seed_sel;
            state  <= SEED;
          end else if (gnt_any) begin
            rr_ptr <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + ONE_IDX;
          end
        end
        default: state <= RST;
      endcase
    end
  end

  // Each grant both latches a sample and advances the generator, so no sample repeats.
  assign ready       = (state == SERVE);
  assign prng_seed   = seed_q;
  assign prng_reset  = (state == RST) || (state == SEED);
  assign prng_enable = (state == WARMUP) || gnt_any;
  assign prng_fetch  = gnt_any;
  assign sample_data = prng_data;

`ifdef PRNG_ARB_STATS_EN
  logic [31:0] count_q;
  always_ff @(posedge clock) begin
    if (!reset)            count_q <= '0;
    else if (sample_valid) count_q <= count_q + 32'd1;
  end
  assign sample_count = count_q;
`else
  assign sample_count = '0;
`endif

endmodule

// File: tb/tb_prng_arbiter.sv
// Bench for prng_arbiter: drives a behavioural generator, checks every cycle against a phase/round-robin reference model.
module tb_prng_arbiter;
  localparam int N  = 4;
  localparam int SW = 43;
  localparam int OW = 32;
  localparam int W  = 64;
  localparam logic [SW-1:0] DEF = 43'h5A5_C3C3_A5A5;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset, reseed;
  logic [SW-1:0] seed_in;
  logic [N-1:0]  req, grant;
  logic          ready, sample_valid;
  logic [1:0]    sample_id;
  logic [OW-1:0] sample_data, prng_data;
  logic [31:0]   sample_count;
  logic [SW-1:0] prng_seed;
  logic          prng_reset, prng_enable, prng_fetch;

  prng_arbiter #(.NUM_REQ(N), .SEED_size(SW), .OUT_size(OW), .WARMUP_CYCLES(W), .DEFAULT_SEED(DEF)) dut (
    .clock(clock), .reset(reset), .seed_in(seed_in), .reseed(reseed), .req(req),
    .grant(grant), .ready(ready), .sample_valid(sample_valid), .sample_id(sample_id),
    .sample_data(sample_data), .sample_count(sample_count), .prng_seed(prng_seed),
    .prng_reset(prng_reset), .prng_enable(prng_enable), .prng_fetch(prng_fetch),
    .prng_data(prng_data)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: k = cycles since seeding (-1 in reset, 0 seed, 1..W warm-up, W+1 serving).
  int            k;
  logic [SW-1:0] m_seed;
  int            m_ptr, m_adv, m_id, m_count;
  bit            m_valid;
  logic [OW-1:0] m_data;
  logic [SW-1:0] g_st;

  function automatic logic [SW-1:0] gen_step(input logic [SW-1:0] s);
    return {s[41:0], s[42] ^ s[38] ^ s[2] ^ s[0]};
  endfunction

  function automatic logic [OW-1:0] gen_mix(input logic [SW-1:0] s);
    return s[31:0] ^ {s[42:32], s[20:0]};
  endfunction

  function automatic logic [OW-1:0] ref_sample(input logic [SW-1:0] s, input int n);
    logic [SW-1:0] t;
    t = s;
    for (int i = 0; i < n; i++) t = gen_step(t);
    return gen_mix(t);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input bit chk_en);
    logic [N-1:0]  eg;
    bit            eg_any, c_rst, c_en, c_f;
    int            egi, c;
    logic [SW-1:0] c_seed, old, ssel;
    #1;
    eg = '0; eg_any = 0; egi = 0;
    if (k > W && !reseed) begin
      for (int i = 0; i < N; i++) begin
        c = (m_ptr + i) % N;
        if (!eg_any && req[c]) begin eg_any = 1; egi = c; end
      end
    end
    if (eg_any) eg[egi] = 1'b1;
    if (chk_en) begin
      chk("grant", grant, eg);
      chk("ready", ready, k > W);
      chk("prng_reset", prng_reset, k <= 0);
      chk("prng_enable", prng_enable, (k >= 1 && k <= W) || eg_any);
      chk("prng_fetch", prng_fetch, eg_any);
      chk("prng_seed", prng_seed, m_seed);
      chk("sample_valid", sample_valid, m_valid);
      if (m_valid) begin
        chk("sample_id", sample_id, m_id);
        chk("sample_data", sample_data, m_data);
      end
`ifdef PRNG_ARB_STATS_EN
      chk("sample_count", sample_count, m_count);
`else
      chk("sample_count", sample_count, 0);
`endif
    end
    c_rst = prng_reset; c_en = prng_enable; c_f = prng_fetch; c_seed = prng_seed;
    @(posedge clock);
    #1;
    old = g_st;
    if (c_rst)     g_st = c_seed;
    else if (c_en) g_st = gen_step(g_st);
    if (c_f) prng_data = gen_mix(old);
    ssel = (seed_in == '0) ? DEF : seed_in;
    if (!reset) begin
      k = -1; m_seed = ssel; m_ptr = 0; m_valid = 0; m_id = 0; m_count = 0;
    end else begin
      if (m_valid) m_count++;
      m_valid = eg_any;
      if (eg_any) begin
        m_id = egi;
        m_data = ref_sample(m_seed, m_adv);
        m_adv++;
        m_ptr = (egi + 1) % N;
      end
      if (k == -1) k = 0;
      else if (k <= W) begin
        if (reseed) begin m_seed = ssel; k = 0; end
        else begin
          k++;
          if (k == 1) m_adv = W;
        end
      end else if (reseed) begin
        m_seed = ssel; k = 0;
      end
    end
    @(negedge clock);
  endtask

  logic [OW-1:0] d[16];
  logic [OW-1:0] first_reset_sample;
  int nd, en_cnt, first_ready, low_cnt, ndup;

  initial begin
    reset = 0; reseed = 0; req = '0; seed_in = 43'h1; prng_data = '0; g_st = '0;
    k = -2; m_seed = '0; m_ptr = 0; m_adv = 0; m_valid = 0; m_id = 0; m_data = '0; m_count = 0;
    @(negedge clock);
    tick(0); tick(1); tick(1);

    // Release: enable for exactly W cycles, ready from cycle W+1.
    reset = 1;
    tick(1);
    en_cnt = 0; first_ready = -1;
    for (int c = 0; c < 70; c++) begin
      en_cnt += int'(prng_enable);
      if (ready && first_ready < 0) first_ready = c;
      tick(1);
    end
    chk("enable_cycles", en_cnt, W);
    chk("ready_cycle", first_ready, W + 1);

    // All requesting: rotating grants, 8 distinct samples.
    req = 4'hF; nd = 0;
    for (int c = 0; c < 10; c++) begin
      if (c == 8) req = '0;
      if (sample_valid) begin d[nd] = sample_data; nd++; end
      tick(1);
    end
    chk("n_samples", nd, 8);
    ndup = 0;
    for (int i = 0; i < 8; i++)
      for (int j = i + 1; j < 8; j++)
        if (d[i] == d[j]) ndup++;
    chk("distinct", ndup, 0);
    first_reset_sample = d[0];
    chk("first_sample", d[0], ref_sample(43'h1, W));

    // Sole requester 2 with pointer moving to 3, then granted every cycle.
    req = 4'b0100;
    repeat (6) tick(1);
    req = '0;
    tick(1);

    // Randomised traffic with rare reseeds.
    for (int c = 0; c < 300; c++) begin
      req = N'($urandom);
      seed_in = ($urandom_range(0, 3) == 0) ? '0 : {11'($urandom), 32'($urandom)};
      reseed = ($urandom_range(0, 149) == 0);
      tick(1);
      reseed = 0;
    end
    req = '0;
    repeat (70) tick(1);

    // Reseed with a sample in flight.
    seed_in = 43'h1; req = 4'h1;
    tick(1);
    chk("inflight_valid", sample_valid, 1);
    reseed = 1; req = 4'hF;
    tick(1);
    reseed = 0; req = '0; low_cnt = 0;
    for (int c = 0; c < 70; c++) begin
      low_cnt += int'(!ready);
      tick(1);
    end
    chk("ready_low_cycles", low_cnt, W + 1);
    req = 4'h1;
    tick(1);
    req = '0;
    chk("reseed_repro", sample_data, first_reset_sample);
    tick(1);

    // Zero seed at reset, then 10 grants.
    reset = 0; seed_in = '0;
    tick(1); tick(1);
    reset = 1;
    tick(1);
    chk("default_seed", prng_seed, DEF);
    repeat (70) tick(1);
    req = 4'h1; nd = 0;
    for (int c = 0; c < 12; c++) begin
      if (c == 10) req = '0;
      if (sample_valid) begin d[nd] = sample_data; nd++; end
      tick(1);
    end
    chk("n_samples2", nd, 10);
    chk("nonconst", d[0] != d[1], 1);
`ifdef PRNG_ARB_STATS_EN
    chk("count_10", sample_count, 10);
`else
    chk("count_off", sample_count, 0);
`endif

    // Reset mid-sample drops it and clears the counter.
    req = 4'h1;
    tick(1);
    reset = 0; req = '0;
    tick(1);
    chk("drop_valid", sample_valid, 0);
    chk("drop_count", sample_count, 0);
    reset = 1;
    repeat (3) tick(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
